// File: rtl/liang_pkg.sv
// Shared types for the decode/dispatch slice of the core.
// Holds the decoded uop format, functional-unit and operation codes,
// dispatch FSM states, and source-register usage helpers.
package liang_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      FU_ALU = 1'b0,
      FU_LSU = 1'b1
   } fu_e;

   typedef enum logic [3:0] {
      OP_NONE   = 4'd0,
      OP_LUI    = 4'd1,
      OP_AUIPC  = 4'd2,
      OP_JAL    = 4'd3,
      OP_JALR   = 4'd4,
      OP_BRANCH = 4'd5,
      OP_LOAD   = 4'd6,
      OP_STORE  = 4'd7,
      OP_ALI    = 4'd8,
      OP_ALR    = 4'd9
   } fu_op_e;

   // ebreak/ecall arrive with fu_op == OP_NONE and their own flag set.
   typedef struct packed {
      fu_e                    fu;
      fu_op_e                 fu_op;
      logic [6:0]             opcode;
      logic [REG_ADDR_W-1:0]  rd;
      logic [REG_ADDR_W-1:0]  rs1;
      logic [REG_ADDR_W-1:0]  rs2;
      logic                   rd_wen;
      logic                   ebreak;
      logic                   ecall;
      logic [31:0]            imm;
   } uop_info_t;

   typedef enum logic [1:0] {
      DSP_RUN   = 2'd0,
      DSP_DRAIN = 2'd1,
      DSP_HALT  = 2'd2
   } dispatch_state_e;

   function automatic logic uses_rs1(input fu_op_e op);
      case (op)
         OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALI, OP_ALR: uses_rs1 = 1'b1;
         default:                                                uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input fu_op_e op);
      case (op)
         OP_BRANCH, OP_STORE, OP_ALR: uses_rs2 = 1'b1;
         default:                     uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dispatch_ctrl_scoreboard.sv
// Register-write scoreboard: one pending-write bit per architectural register.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   set_en/set_rd          mark rd as pending (issue of a writing uop)
//   clr0_en/clr0_rd        clear from ALU writeback
//   clr1_en/clr1_rd        clear from LSU writeback
//   rs1/rs2/rd             lookup addresses
//   busy_rs1/rs2/rd        pending bit of each lookup
//   any_busy               at least one register pending
module dispatch_ctrl_scoreboard
   import liang_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_rd,
   input  logic                  clr0_en,
   input  logic [REG_ADDR_W-1:0] clr0_rd,
   input  logic                  clr1_en,
   input  logic [REG_ADDR_W-1:0] clr1_rd,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic                  busy_rs1,
   output logic                  busy_rs2,
   output logic                  busy_rd,
   output logic                  any_busy
);

   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_d;

   // Clears are applied before the set so a same-cycle set on the same
   // register survives; the in-flight op it tracks is newer than the
   // writeback being retired.
   always_comb begin
      sb_d = sb_q;
      if (clr0_en) sb_d[clr0_rd] = 1'b0;
      if (clr1_en) sb_d[clr1_rd] = 1'b0;
      if (set_en)  sb_d[set_rd]  = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sb_q <= '0;
      else         sb_q <= sb_d;
   end

   assign busy_rs1 = sb_q[rs1];
   assign busy_rs2 = sb_q[rs2];
   assign busy_rd  = sb_q[rd];
   assign any_busy = |sb_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Issue/dispatch controller between decoder and functional units.
// Holds one decoded uop, checks RAW/WAW hazards against a scoreboard and
// issues to the ALU or LSU port with valid/ready. ebreak/ecall drain all
// outstanding work before the system pulse; illegal uops halt.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   flush_i                    drop the held uop
//   in_valid_i/in_ready_o/uop_i decoder handshake
//   alu_*/lsu_*                issue ports
//   wb_alu_*/wb_lsu_*          writebacks clearing the scoreboard
//   lsu_done_i                 one pulse per completed LSU op
//   ebreak_o/ecall_o/illegal_o one-cycle event pulses
//   halted_o, busy_o           status
//
// state     | meaning
// DSP_RUN   | normal issue
// DSP_DRAIN | system uop held, waiting for scoreboard and LSU to empty
// DSP_HALT  | stopped after ebreak or illegal; left only by reset
module dispatch_ctrl
   import liang_pkg::*;
#(
   parameter int NREG        = 32,
   parameter int LSU_MAX_OUT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  uop_info_t             uop_i,
   output logic                  alu_valid_o,
   input  logic                  alu_ready_i,
   output uop_info_t             alu_uop_o,
   output logic                  lsu_valid_o,
   input  logic                  lsu_ready_i,
   output uop_info_t             lsu_uop_o,
   input  logic                  wb_alu_valid_i,
   input  logic [REG_ADDR_W-1:0] wb_alu_rd_i,
   input  logic                  wb_lsu_valid_i,
   input  logic [REG_ADDR_W-1:0] wb_lsu_rd_i,
   input  logic                  lsu_done_i,
   output logic                  ebreak_o,
   output logic                  ecall_o,
   output logic                  illegal_o,
   output logic                  halted_o,
   output logic                  busy_o
);

   dispatch_state_e state_q, state_d;
   logic            slot_v_q;
   uop_info_t       slot_q;
   logic [2:0]      lsu_cnt_q;

   logic busy_rs1, busy_rs2, busy_rd, sb_any;
   logic is_sys, is_illegal, hazard, issuable;
   logic alu_fire, lsu_fire, issue_fire, accept, drop_slot;

   dispatch_ctrl_scoreboard #(.NREG(NREG)) u_sb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .set_en   (issue_fire && slot_q.rd_wen),
      .set_rd   (slot_q.rd),
      .clr0_en  (wb_alu_valid_i),
      .clr0_rd  (wb_alu_rd_i),
      .clr1_en  (wb_lsu_valid_i),
      .clr1_rd  (wb_lsu_rd_i),
      .rs1      (slot_q.rs1),
      .rs2      (slot_q.rs2),
      .rd       (slot_q.rd),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2),
      .busy_rd  (busy_rd),
      .any_busy (sb_any)
   );

   assign is_sys     = slot_q.ebreak || slot_q.ecall;
   assign is_illegal = (slot_q.fu_op == OP_NONE) && !is_sys;
   assign hazard     = (uses_rs1(slot_q.fu_op) && busy_rs1)
                    || (uses_rs2(slot_q.fu_op) && busy_rs2)
                    || (slot_q.rd_wen && busy_rd);

   // Hazards only ever clear and lsu_cnt only grows through this slot, so
   // once a valid rises it cannot fall until fire or flush.
   assign issuable    = slot_v_q && (state_q == DSP_RUN) && !is_sys && !is_illegal && !hazard;
   assign alu_valid_o = issuable && (slot_q.fu != FU_LSU);
   assign lsu_valid_o = issuable && (slot_q.fu == FU_LSU) && (lsu_cnt_q < 3'(LSU_MAX_OUT));

   // Flush wins over a handshake presented in the same cycle.
   assign alu_fire   = alu_valid_o && alu_ready_i && !flush_i;
   assign lsu_fire   = lsu_valid_o && lsu_ready_i && !flush_i;
   assign issue_fire = alu_fire || lsu_fire;

   assign in_ready_o = (state_q == DSP_RUN) && !flush_i && (!slot_v_q || issue_fire);
   assign accept     = in_valid_i && in_ready_o;

   assign alu_uop_o = slot_q;
   assign lsu_uop_o = slot_q;
   assign halted_o  = (state_q == DSP_HALT);
   assign busy_o    = slot_v_q || sb_any || (lsu_cnt_q != 3'd0);

   always_comb begin
      state_d   = state_q;
      ebreak_o  = 1'b0;
      ecall_o   = 1'b0;
      illegal_o = 1'b0;
      drop_slot = 1'b0;
      case (state_q)
         DSP_RUN: begin
            if (slot_v_q && !flush_i) begin
               if (is_sys) begin
                  state_d = DSP_DRAIN;
               end else if (is_illegal) begin
                  illegal_o = 1'b1;
                  drop_slot = 1'b1;
                  state_d   = DSP_HALT;
               end
            end
         end
         DSP_DRAIN: begin
            if (flush_i) begin
               state_d = DSP_RUN;
            end else if (!sb_any && (lsu_cnt_q == 3'd0)) begin
               drop_slot = 1'b1;
               if (slot_q.ebreak) begin
                  ebreak_o = 1'b1;
                  state_d  = DSP_HALT;
               end else begin
                  ecall_o = 1'b1;
                  state_d = DSP_RUN;
               end
            end
         end
         DSP_HALT: state_d = DSP_HALT;
         default:  state_d = DSP_RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= DSP_RUN;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_v_q <= 1'b0;
         slot_q   <= '0;
      end else if (flush_i && (state_q != DSP_HALT)) begin
         slot_v_q <= 1'b0;
      end else if (accept) begin
         slot_v_q <= 1'b1;
         slot_q   <= uop_i;
      end else if (issue_fire || drop_slot) begin
         slot_v_q <= 1'b0;
      end
   end

   // Issue is blocked at LSU_MAX_OUT, so only the decrement needs a guard.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lsu_cnt_q <= '0;
      end else if (lsu_fire && !lsu_done_i) begin
         lsu_cnt_q <= lsu_cnt_q + 3'd1;
      end else if (!lsu_fire && lsu_done_i && (lsu_cnt_q != 3'd0)) begin
         lsu_cnt_q <= lsu_cnt_q - 3'd1;
      end
   end

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
   import liang_pkg::*;

   logic      clk_i = 1'b0;
   logic      rst_ni, flush_i, in_valid_i, alu_ready_i, lsu_ready_i;
   logic      wb_alu_valid_i, wb_lsu_valid_i, lsu_done_i;
   logic [4:0] wb_alu_rd_i, wb_lsu_rd_i;
   uop_info_t uop_i, alu_uop_o, lsu_uop_o;
   logic      in_ready_o, alu_valid_o, lsu_valid_o;
   logic      ebreak_o, ecall_o, illegal_o, halted_o, busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   dispatch_ctrl #(.NREG(32), .LSU_MAX_OUT(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .uop_i(uop_i),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_uop_o(alu_uop_o),
      .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i), .lsu_uop_o(lsu_uop_o),
      .wb_alu_valid_i(wb_alu_valid_i), .wb_alu_rd_i(wb_alu_rd_i),
      .wb_lsu_valid_i(wb_lsu_valid_i), .wb_lsu_rd_i(wb_lsu_rd_i),
      .lsu_done_i(lsu_done_i), .ebreak_o(ebreak_o), .ecall_o(ecall_o),
      .illegal_o(illegal_o), .halted_o(halted_o), .busy_o(busy_o)
   );

   function automatic uop_info_t mk(input fu_e fu, input fu_op_e op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic wen, input logic eb, input logic ec,
                                    input logic [6:0] opc);
      uop_info_t u;
      u = '0;
      u.fu = fu; u.fu_op = op; u.rd = rd; u.rs1 = rs1; u.rs2 = rs2;
      u.rd_wen = wen; u.ebreak = eb; u.ecall = ec; u.opcode = opc;
      u.imm = 32'h1;
      return u;
   endfunction

   uop_info_t ADD5, ADDI6, ADDI9, ADDI10, ADDI0, ADDI11, LW7, LW8, LW3, EBRK, ECAL, ILL;

   task tick;
      @(posedge clk_i); #1;
   endtask

   task idle;
      flush_i = 0; in_valid_i = 0; alu_ready_i = 0; lsu_ready_i = 0;
      wb_alu_valid_i = 0; wb_lsu_valid_i = 0; lsu_done_i = 0;
      wb_alu_rd_i = 0; wb_lsu_rd_i = 0; uop_i = '0;
   endtask

   task do_reset;
      rst_ni = 0; idle();
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
   endtask

   task test_reset;
      rst_ni = 0; idle(); #3;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL rst_alu_valid got %b exp 0", alu_valid_o); end
      checks++; if (lsu_valid_o !== 1'b0) begin errors++; $display("FAIL rst_lsu_valid got %b exp 0", lsu_valid_o); end
      checks++; if ({ebreak_o, ecall_o, illegal_o, halted_o, busy_o} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {ebreak_o, ecall_o, illegal_o, halted_o, busy_o}); end
      checks++; if (alu_uop_o !== uop_info_t'('0)) begin errors++; $display("FAIL rst_uop got %h exp 0", alu_uop_o); end
      do_reset(); #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready_o); end
   endtask

   task test_raw;
      do_reset();
      uop_i = ADD5; in_valid_i = 1; #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL raw_accept got %b exp 1", in_ready_o); end
      tick();
      uop_i = ADDI6; alu_ready_i = 1; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL raw_add_valid got %b exp 1", alu_valid_o); end
      checks++; if (alu_uop_o !== ADD5) begin errors++; $display("FAIL raw_add_uop got %h exp %h", alu_uop_o, ADD5); end
      tick();
      in_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", alu_valid_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL raw_busy got %b exp 1", busy_o); end
      tick();
      wb_alu_valid_i = 1; wb_alu_rd_i = 5; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %b exp 0", alu_valid_o); end
      tick();
      wb_alu_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL raw_after_wb got %b exp 1", alu_valid_o); end
      checks++; if (alu_uop_o !== ADDI6) begin errors++; $display("FAIL raw_addi_uop got %h exp %h", alu_uop_o, ADDI6); end
      tick();
      wb_alu_valid_i = 1; wb_alu_rd_i = 6; alu_ready_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL raw_empty got %b exp 0", alu_valid_o); end
      tick();
      idle(); #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL raw_idle_busy got %b exp 0", busy_o); end
   endtask

   task test_lsu;
      do_reset();
      uop_i = LW7; in_valid_i = 1; lsu_ready_i = 0; #1;
      tick();
      in_valid_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (lsu_valid_o !== 1'b1) begin errors++; $display("FAIL lsu_bp_valid[%0d] got %b exp 1", i, lsu_valid_o); end
         checks++; if (lsu_uop_o !== LW7) begin errors++; $display("FAIL lsu_bp_uop[%0d] got %h exp %h", i, lsu_uop_o, LW7); end
         tick();
      end
      lsu_ready_i = 1; in_valid_i = 1; uop_i = LW8; #1;
      checks++; if (lsu_valid_o !== 1'b1) begin errors++; $display("FAIL lsu_fire_valid got %b exp 1", lsu_valid_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL lsu_refill_ready got %b exp 1", in_ready_o); end
      tick();
      uop_i = ADDI11; #1;
      checks++; if (lsu_valid_o !== 1'b0) begin errors++; $display("FAIL lsu_max_out got %b exp 0", lsu_valid_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL lsu_max_ready got %b exp 0", in_ready_o); end
      tick();
      in_valid_i = 0; lsu_done_i = 1; #1;
      checks++; if (lsu_valid_o !== 1'b0) begin errors++; $display("FAIL lsu_done_cycle got %b exp 0", lsu_valid_o); end
      tick();
      lsu_done_i = 0; #1;
      checks++; if (lsu_valid_o !== 1'b1) begin errors++; $display("FAIL lsu_second got %b exp 1", lsu_valid_o); end
      checks++; if (lsu_uop_o !== LW8) begin errors++; $display("FAIL lsu_second_uop got %h exp %h", lsu_uop_o, LW8); end
      tick();
      in_valid_i = 1; uop_i = ADDI11; #1;
      tick();
      in_valid_i = 0; alu_ready_i = 1; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL lsu_sb7_set got %b exp 0", alu_valid_o); end
      tick();
      wb_lsu_valid_i = 1; wb_lsu_rd_i = 7; lsu_done_i = 1; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL lsu_sb7_wb got %b exp 0", alu_valid_o); end
      tick();
      wb_lsu_valid_i = 0; lsu_done_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL lsu_sb7_clear got %b exp 1", alu_valid_o); end
      tick();
      wb_alu_valid_i = 1; wb_alu_rd_i = 11; wb_lsu_valid_i = 1; wb_lsu_rd_i = 8; #1;
      tick();
      idle(); #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lsu_idle_busy got %b exp 0", busy_o); end
   endtask

   task test_set_clear;
      do_reset();
      in_valid_i = 1; uop_i = ADDI9; #1;
      tick();
      alu_ready_i = 1; wb_alu_valid_i = 1; wb_alu_rd_i = 9; uop_i = ADDI10; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL sc_issue9 got %b exp 1", alu_valid_o); end
      tick();
      in_valid_i = 0; wb_alu_rd_i = 0; wb_lsu_valid_i = 1; wb_lsu_rd_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL sc_set_wins got %b exp 0", alu_valid_o); end
      tick();
      wb_alu_rd_i = 9; wb_lsu_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL sc_x0_wb got %b exp 0", alu_valid_o); end
      tick();
      wb_alu_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL sc_clear9 got %b exp 1", alu_valid_o); end
      tick();
      wb_alu_valid_i = 1; wb_alu_rd_i = 10; wb_lsu_valid_i = 1; wb_lsu_rd_i = 10;
      in_valid_i = 1; uop_i = ADDI0; #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL sc_ready_x0 got %b exp 1", in_ready_o); end
      tick();
      wb_alu_valid_i = 0; wb_lsu_valid_i = 0; in_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL sc_x0_issue got %b exp 1", alu_valid_o); end
      tick();
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sc_x0_nowrite got %b exp 0", busy_o); end
      idle();
   endtask

   task test_ebreak_drain;
      do_reset();
      in_valid_i = 1; uop_i = LW3; lsu_ready_i = 1; #1;
      tick();
      uop_i = EBRK; #1;
      checks++; if (lsu_valid_o !== 1'b1) begin errors++; $display("FAIL eb_lw_valid got %b exp 1", lsu_valid_o); end
      tick();
      in_valid_i = 0; #1;
      checks++; if (ebreak_o !== 1'b0) begin errors++; $display("FAIL eb_early got %b exp 0", ebreak_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL eb_ready_run got %b exp 0", in_ready_o); end
      tick();
      wb_lsu_valid_i = 1; wb_lsu_rd_i = 3; #1;
      checks++; if (ebreak_o !== 1'b0) begin errors++; $display("FAIL eb_drain_sb got %b exp 0", ebreak_o); end
      tick();
      wb_lsu_valid_i = 0; lsu_done_i = 1; #1;
      checks++; if (ebreak_o !== 1'b0) begin errors++; $display("FAIL eb_drain_cnt got %b exp 0", ebreak_o); end
      tick();
      lsu_done_i = 0; #1;
      checks++; if (ebreak_o !== 1'b1) begin errors++; $display("FAIL eb_pulse got %b exp 1", ebreak_o); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL eb_halt_early got %b exp 0", halted_o); end
      tick();
      in_valid_i = 1; uop_i = ADD5; flush_i = 1; #1;
      checks++; if (ebreak_o !== 1'b0) begin errors++; $display("FAIL eb_one_pulse got %b exp 0", ebreak_o); end
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL eb_halted got %b exp 1", halted_o); end
      tick();
      flush_i = 0; #1;
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL eb_halt_flush got %b exp 1", halted_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL eb_halt_ready got %b exp 0", in_ready_o); end
      idle();
   endtask

   task test_ecall_illegal;
      do_reset();
      in_valid_i = 1; uop_i = ECAL; #1;
      tick();
      in_valid_i = 0; #1;
      checks++; if (ecall_o !== 1'b0) begin errors++; $display("FAIL ec_early got %b exp 0", ecall_o); end
      tick();
      #1;
      checks++; if (ecall_o !== 1'b1) begin errors++; $display("FAIL ec_pulse got %b exp 1", ecall_o); end
      tick();
      #1;
      checks++; if (ecall_o !== 1'b0) begin errors++; $display("FAIL ec_one_pulse got %b exp 0", ecall_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ec_run_ready got %b exp 1", in_ready_o); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL ec_not_halted got %b exp 0", halted_o); end
      in_valid_i = 1; uop_i = ILL;
      tick();
      in_valid_i = 0; #1;
      checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b exp 1", illegal_o); end
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL ill_no_issue got %b exp 0", alu_valid_o); end
      tick();
      #1;
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL ill_one_pulse got %b exp 0", illegal_o); end
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL ill_halted got %b exp 1", halted_o); end
      idle();
   endtask

   task test_flush;
      do_reset();
      in_valid_i = 1; uop_i = ADD5; #1;
      tick();
      uop_i = ADDI6; alu_ready_i = 1; #1;
      tick();
      uop_i = LW7; flush_i = 1; #1;
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", in_ready_o); end
      tick();
      flush_i = 0; in_valid_i = 0; #1;
      checks++; if ({alu_valid_o, lsu_valid_o} !== 2'b00) begin errors++; $display("FAIL fl_empty got %b exp 00", {alu_valid_o, lsu_valid_o}); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL fl_sb_kept got %b exp 1", busy_o); end
      in_valid_i = 1; uop_i = ADDI6;
      tick();
      in_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b0) begin errors++; $display("FAIL fl_sb5_stall got %b exp 0", alu_valid_o); end
      tick();
      wb_alu_valid_i = 1; wb_alu_rd_i = 5; #1;
      tick();
      wb_alu_valid_i = 0; #1;
      checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL fl_sb5_clear got %b exp 1", alu_valid_o); end
      tick();
      in_valid_i = 1; uop_i = ECAL; wb_alu_valid_i = 1; wb_alu_rd_i = 6; #1;
      tick();
      in_valid_i = 0; wb_alu_valid_i = 0; #1;
      tick();
      flush_i = 1; #1;
      checks++; if (ecall_o !== 1'b0) begin errors++; $display("FAIL fl_drain_pulse got %b exp 0", ecall_o); end
      tick();
      flush_i = 0; #1;
      checks++; if (ecall_o !== 1'b0) begin errors++; $display("FAIL fl_drain_after got %b exp 0", ecall_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL fl_drain_run got %b exp 1", in_ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fl_drain_idle got %b exp 0", busy_o); end
      idle();
   endtask

   task test_async_reset;
      do_reset();
      in_valid_i = 1; uop_i = LW7; lsu_ready_i = 0; #1;
      tick();
      in_valid_i = 0; #1;
      checks++; if (lsu_valid_o !== 1'b1) begin errors++; $display("FAIL ar_stall got %b exp 1", lsu_valid_o); end
      #3 rst_ni = 0; #1;
      checks++; if (lsu_valid_o !== 1'b0) begin errors++; $display("FAIL ar_lsu_valid got %b exp 0", lsu_valid_o); end
      checks++; if (lsu_uop_o !== uop_info_t'('0)) begin errors++; $display("FAIL ar_lsu_uop got %h exp 0", lsu_uop_o); end
      checks++; if ({alu_valid_o, busy_o, halted_o} !== 3'b000) begin errors++; $display("FAIL ar_flags got %b exp 000", {alu_valid_o, busy_o, halted_o}); end
      tick();
      idle();
   endtask

   initial begin
      ADD5   = mk(FU_ALU, OP_ALR, 5'd5,  5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 7'h33);
      ADDI6  = mk(FU_ALU, OP_ALI, 5'd6,  5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 7'h13);
      ADDI9  = mk(FU_ALU, OP_ALI, 5'd9,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 7'h13);
      ADDI10 = mk(FU_ALU, OP_ALI, 5'd10, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 7'h13);
      ADDI0  = mk(FU_ALU, OP_ALI, 5'd0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 7'h13);
      ADDI11 = mk(FU_ALU, OP_ALI, 5'd11, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 7'h13);
      LW7    = mk(FU_LSU, OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 7'h03);
      LW8    = mk(FU_LSU, OP_LOAD, 5'd8, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 7'h03);
      LW3    = mk(FU_LSU, OP_LOAD, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 7'h03);
      EBRK   = mk(FU_ALU, OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'h73);
      ECAL   = mk(FU_ALU, OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'h73);
      ILL    = mk(FU_ALU, OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'h7f);
      test_reset();
      test_raw();
      test_lsu();
      test_set_clear();
      test_ebreak_drain();
      test_ecall_illegal();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
